ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port data RAM between two requesters: port 0 = CPU-side MIO bus path,
//  port 1 = debug/monitor reader (memory dump to display mux). One transaction in flight;
//  req/ack handshake per port; registered RAM-side outputs; fixed or round-robin arbitration.
// PARAMETERS
//  ADDR_W        10  RAM word-address width
//  DATA_W        32  data width
//  RD_LAT        1   RAM read latency in cycles (1..3), from issue cycle to dout valid
//  CPU_PRIORITY  1   1: port 0 always wins a tie; 0: round-robin between ports
// PORTS
//  clk       in   1       system clock, all logic on rising edge
//  rst       in   1       synchronous reset, active-high
//  p0_req    in   1       port 0 request, held until p0_ack
//  p0_we     in   1       port 0 write (1) / read (0)
//  p0_addr   in   ADDR_W  port 0 word address
//  p0_wdata  in   DATA_W  port 0 write data
//  p0_ack    out  1       one-cycle completion pulse
//  p0_rdata  out  DATA_W  read data, valid while p0_ack=1, held until next port 0 read
//  p1_*      --   --      identical set for port 1 (req, we, addr, wdata, ack, rdata)
//  ram_we    out  1       RAM write enable, exactly one cycle per write
//  ram_addr  out  ADDR_W  RAM address
//  ram_din   out  DATA_W  RAM write data
//  ram_dout  in   DATA_W  RAM read data
//  busy      out  1       high in any state other than IDLE
//  grant_id  out  1       port owning the current/last transaction
// BEHAVIOUR
//  Reset: state=IDLE, ram_we=0, ram_addr=0, ram_din=0, p0/p1_ack=0, p0/p1_rdata=0,
//   busy=0, grant_id=0, last_grant=1 (port 0 wins first RR decision). Applies mid-transaction:
//   in-flight access abandoned, no ack issued, ram_we low from the reset edge on.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE : sample p0_req/p1_req; none -> stay. Winner registered into grant_id; its addr,
//          we, wdata latched into ram_addr/ram_we/ram_din; go ISSUE.
//   ISSUE: RAM driven for exactly this cycle; ram_we cleared on exit; wait counter=RD_LAT-1.
//   WAIT : decrement counter; at 0 go RESP (RD_LAT=1 -> WAIT lasts one cycle).
//   RESP : ack of granted port high this cycle only; on read, rdata<=ram_dout captured on
//          entry so it is valid during ack; on write, rdata unchanged; last_grant<=grant_id.
//  Latency: req sampled at edge k -> ack high in cycle k+RD_LAT+2 (reads and writes equal).
//  Arbitration: both req in IDLE: CPU_PRIORITY=1 -> port 0; else port != last_grant.
//   Single req -> that port regardless of mode. Loser keeps req high, served next IDLE.
//  Handshake: requester holds req/we/addr/wdata stable until ack; drops req the edge after
//   ack at latest. Inputs latched at grant; changes after grant are ignored.
//  Req withdrawn before ack: transaction still completes, ack still pulsed.
//  Back-to-back: RESP always returns to IDLE; min spacing between grants = RD_LAT+3 cycles.
//  Round-robin fairness: with both req held continuously, grants strictly alternate.
//  Address/data width: no range check; addr passed through unmodified.
//  ram_addr/ram_din hold their last value outside ISSUE (ram_we=0 there).
// STRUCTURE
//  Shared package ram_arb_pkg: state enum {IDLE,ISSUE,WAIT,RESP}, PORT_CPU=1'b0,
//   PORT_DBG=1'b1, RD_LAT bounds constants.
//  One sub-module: arb2_rr (2-way grant decision from req, last_grant, CPU_PRIORITY;
//   combinational). FSM, latches, counter and output registers in top level.
// TESTING
//  T1 reset: rst=1 mid-WAIT of a read -> next cycle IDLE, busy=0, ram_we=0, no ack ever.
//  T2 p0 write addr=0x005 data=0xDEADBEEF, then p0 read 0x005 -> ram_we one cycle;
//     read ack in cycle k+3 (RD_LAT=1) with p0_rdata=0xDEADBEEF.
//  T3 CPU_PRIORITY=1, both req held, p1 read 0x010 -> p0 served twice first? no: p0 wins
//     each tie; p1 granted only once p0_req drops; p1_rdata = RAM[0x010].
//  T4 CPU_PRIORITY=0, both req held for 4 transactions -> grant_id 0,1,0,1.
//  T5 RD_LAT=3, p1 read 0x3FF (wrap max addr) -> ack at k+5, ram_addr=0x3FF, data correct.
//  T6 p0 drops req in WAIT -> p0_ack still pulses once; no second transaction issued.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;
   // Wait counter only ever holds RD_LAT-1.
   localparam int CNT_W      = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/ram_port_arbiter_arb2_rr.sv
// Two-way grant decision: fixed CPU priority or round-robin against the last granted port.
module arb2_rr
   import ram_arb_pkg::*;
#(
   parameter int CPU_PRIORITY = 1
) (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt_id
);

   always_comb begin
      gnt_valid = req0 | req1;
      gnt_id    = PORT_CPU;
      if (req0 && req1) begin
         // On a tie in round-robin mode the port that did not go last wins.
         gnt_id = (CPU_PRIORITY != 0) ? PORT_CPU : ~last_grant;
      end else if (req1) begin
         gnt_id = PORT_DBG;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between a CPU port and a debug reader port,
// one transaction at a time, with registered RAM-side and response outputs.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int RD_LAT       = 1,
   parameter int CPU_PRIORITY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy,
   output logic              grant_id
);

   state_e             state_q, state_d;
   logic               grant_q, grant_d;
   logic               last_grant_q, last_grant_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_we_q, op_we_d;
   logic               ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]  ram_din_q, ram_din_d;
   logic               p0_ack_q, p0_ack_d;
   logic               p1_ack_q, p1_ack_d;
   logic [DATA_W-1:0]  p0_rdata_q, p0_rdata_d;
   logic [DATA_W-1:0]  p1_rdata_q, p1_rdata_d;
   logic               busy_q, busy_d;

   logic               gnt_valid;
   logic               gnt_id;

   arb2_rr #(
      .CPU_PRIORITY (CPU_PRIORITY)
   ) u_arb (
      .req0       (p0_req),
      .req1       (p1_req),
      .last_grant (last_grant_q),
      .gnt_valid  (gnt_valid),
      .gnt_id     (gnt_id)
   );

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      op_we_d      = op_we_q;
      ram_we_d     = 1'b0;
      ram_addr_d   = ram_addr_q;
      ram_din_d    = ram_din_q;
      p0_ack_d     = 1'b0;
      p1_ack_d     = 1'b0;
      p0_rdata_d   = p0_rdata_q;
      p1_rdata_d   = p1_rdata_q;

      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               state_d = ISSUE;
               grant_d = gnt_id;
               if (gnt_id == PORT_DBG) begin
                  op_we_d    = p1_we;
                  ram_we_d   = p1_we;
                  ram_addr_d = p1_addr;
                  ram_din_d  = p1_wdata;
               end else begin
                  op_we_d    = p0_we;
                  ram_we_d   = p0_we;
                  ram_addr_d = p0_addr;
                  ram_din_d  = p0_wdata;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            cnt_d   = CNT_W'(RD_LAT - 1);
         end
         WAIT: begin
            if (cnt_q == '0) begin
               // ram_dout is valid in this last WAIT cycle; capture it on entry to RESP.
               state_d = RESP;
               if (grant_q == PORT_DBG) begin
                  p1_ack_d = 1'b1;
                  if (!op_we_q) p1_rdata_d = ram_dout;
               end else begin
                  p0_ack_d = 1'b1;
                  if (!op_we_q) p0_rdata_d = ram_dout;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d      = IDLE;
            last_grant_d = grant_q;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= PORT_CPU;
         last_grant_q <= PORT_DBG;
         cnt_q        <= '0;
         op_we_q      <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_din_q    <= '0;
         p0_ack_q     <= 1'b0;
         p1_ack_q     <= 1'b0;
         p0_rdata_q   <= '0;
         p1_rdata_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         op_we_q      <= op_we_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_din_q    <= ram_din_d;
         p0_ack_q     <= p0_ack_d;
         p1_ack_q     <= p1_ack_d;
         p0_rdata_q   <= p0_rdata_d;
         p1_rdata_q   <= p1_rdata_d;
         busy_q       <= busy_d;
      end
   end

   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;
   assign p0_ack   = p0_ack_q;
   assign p1_ack   = p1_ack_q;
   assign p0_rdata = p0_rdata_q;
   assign p1_rdata = p1_rdata_q;
   assign busy     = busy_q;
   assign grant_id = grant_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: instance A (RD_LAT=1, CPU priority), instance B (RD_LAT=3, round-robin).
module tb_ram_port_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int EW = 49;   // {ack_cycle[15:0], port, rdata[31:0]}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Port index p = inst*2 + port
   logic [3:0]      req   = '0;
   logic [3:0]      we_i  = '0;
   logic [4*AW-1:0] addr  = '0;
   logic [4*DW-1:0] wdata = '0;
   logic [3:0]      ack;
   logic [4*DW-1:0] rdata;
   logic [1:0]      ram_we;
   logic [2*AW-1:0] ram_addr;
   logic [2*DW-1:0] ram_din;
   logic [2*DW-1:0] ram_dout;
   logic [1:0]      busy;
   logic [1:0]      grant;

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .CPU_PRIORITY(1)) dut_a (
      .clk(clk), .rst(rst),
      .p0_req(req[0]), .p0_we(we_i[0]), .p0_addr(addr[0*AW +: AW]), .p0_wdata(wdata[0*DW +: DW]),
      .p0_ack(ack[0]), .p0_rdata(rdata[0*DW +: DW]),
      .p1_req(req[1]), .p1_we(we_i[1]), .p1_addr(addr[1*AW +: AW]), .p1_wdata(wdata[1*DW +: DW]),
      .p1_ack(ack[1]), .p1_rdata(rdata[1*DW +: DW]),
      .ram_we(ram_we[0]), .ram_addr(ram_addr[0*AW +: AW]), .ram_din(ram_din[0*DW +: DW]),
      .ram_dout(ram_dout[0*DW +: DW]), .busy(busy[0]), .grant_id(grant[0])
   );

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .CPU_PRIORITY(0)) dut_b (
      .clk(clk), .rst(rst),
      .p0_req(req[2]), .p0_we(we_i[2]), .p0_addr(addr[2*AW +: AW]), .p0_wdata(wdata[2*DW +: DW]),
      .p0_ack(ack[2]), .p0_rdata(rdata[2*DW +: DW]),
      .p1_req(req[3]), .p1_we(we_i[3]), .p1_addr(addr[3*AW +: AW]), .p1_wdata(wdata[3*DW +: DW]),
      .p1_ack(ack[3]), .p1_rdata(rdata[3*DW +: DW]),
      .ram_we(ram_we[1]), .ram_addr(ram_addr[1*AW +: AW]), .ram_din(ram_din[1*DW +: DW]),
      .ram_dout(ram_dout[1*DW +: DW]), .busy(busy[1]), .grant_id(grant[1])
   );

   // RAM models: word i preloaded with 0x1000_0000+i; read data appears LAT cycles after issue.
   for (genvar g = 0; g < 2; g++) begin : g_ram
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [DW-1:0] mem [1024];
      logic [DW-1:0] pipe [3];
      initial begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      end
      always @(posedge clk) begin
         if (ram_we[g]) mem[ram_addr[g*AW +: AW]] <= ram_din[g*DW +: DW];
         pipe[0] <= mem[ram_addr[g*AW +: AW]];
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
      assign ram_dout[g*DW +: DW] = pipe[LAT-1];
   end

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q0[$];
   logic [EW-1:0] exp_q1[$];
   int n_chk = 0;
   int n_fail = 0;
   int we_cnt [2] = '{0, 0};
   int busy_cnt_a = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int inst, input int port, input logic [DW-1:0] d, input int at);
      logic [EW-1:0] e;
      e = {16'(at), 1'(port), d};
      if (inst == 0) exp_q0.push_back(e);
      else           exp_q1.push_back(e);
   endtask

   task automatic check_ack(input int inst, input int port);
      logic [EW-1:0] e;
      int p;
      p = inst * 2 + port;
      if ((inst == 0 && exp_q0.size() == 0) || (inst == 1 && exp_q1.size() == 0)) begin
         n_chk++;
         n_fail++;
         $display("FAIL unexpected_ack: inst %0d port %0d acked with nothing expected (cycle %0d)",
                  inst, port, cyc);
      end else begin
         if (inst == 0) e = exp_q0.pop_front();
         else           e = exp_q1.pop_front();
         chk($sformatf("ack_port_i%0d", inst), 64'(port), 64'(e[32]));
         chk($sformatf("ack_grant_id_i%0d", inst), 64'(grant[inst]), 64'(e[32]));
         chk($sformatf("ack_rdata_i%0d_p%0d", inst, port), 64'(rdata[p*DW +: DW]), 64'(e[31:0]));
         if (e[48:33] != 16'd0)
            chk($sformatf("ack_cycle_i%0d_p%0d", inst, port), 64'(cyc), 64'(e[48:33]));
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         for (int p = 0; p < 4; p++) begin
            if (ack[p]) check_ack(p / 2, p % 2);
         end
         for (int i = 0; i < 2; i++) begin
            if (ram_we[i]) we_cnt[i]++;
         end
         if (busy[0]) busy_cnt_a++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int inst, input int port, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      int p;
      p = inst * 2 + port;
      req[p]            = 1'b1;
      we_i[p]           = w;
      addr[p*AW +: AW]  = a;
      wdata[p*DW +: DW] = d;
   endtask

   task automatic wait_ack(input int inst, input int port, input bit hold);
      int p;
      bit got;
      p = inst * 2 + port;
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (ack[p]) got = 1'b1;
      end
      if (!got) begin
         n_chk++;
         n_fail++;
         $display("FAIL ack_timeout: inst %0d port %0d no ack within 40 cycles", inst, port);
      end
      @(posedge clk);
      #1;
      if (!hold) req[p] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int c;
      int w0;
      int b0;

      rst = 1'b1;
      tick(3);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_busy_i%0d", i), 64'(busy[i]), 64'd0);
         chk($sformatf("rst_grant_i%0d", i), 64'(grant[i]), 64'd0);
         chk($sformatf("rst_ram_we_i%0d", i), 64'(ram_we[i]), 64'd0);
         chk($sformatf("rst_ram_addr_i%0d", i), 64'(ram_addr[i*AW +: AW]), 64'd0);
         chk($sformatf("rst_ram_din_i%0d", i), 64'(ram_din[i*DW +: DW]), 64'd0);
      end
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("rst_ack_%0d", p), 64'(ack[p]), 64'd0);
         chk($sformatf("rst_rdata_%0d", p), 64'(rdata[p*DW +: DW]), 64'd0);
      end
      rst = 1'b0;
      tick(2);

      // T1: reset lands while a read waits on the RAM; no ack may follow.
      drive(0, 0, 1'b0, 10'h020, 32'h0);
      tick(2);
      chk("t1_busy_in_wait", 64'(busy[0]), 64'd1);
      rst = 1'b1;
      req[0] = 1'b0;
      tick(1);
      chk("t1_busy_after_rst", 64'(busy[0]), 64'd0);
      chk("t1_ram_we_after_rst", 64'(ram_we[0]), 64'd0);
      chk("t1_ack_after_rst", 64'(ack[0]), 64'd0);
      rst = 1'b0;
      tick(8);

      // T2: write 0xDEADBEEF to 0x005, then read it back.
      c = cyc;
      w0 = we_cnt[0];
      push_exp(0, 0, 32'h0, c + 3);
      drive(0, 0, 1'b1, 10'h005, 32'hDEAD_BEEF);
      tick(1);
      chk("t2_ram_we_issue", 64'(ram_we[0]), 64'd1);
      chk("t2_ram_addr_issue", 64'(ram_addr[0 +: AW]), 64'h005);
      chk("t2_ram_din_issue", 64'(ram_din[0 +: DW]), 64'hDEAD_BEEF);
      tick(1);
      chk("t2_ram_we_after", 64'(ram_we[0]), 64'd0);
      wait_ack(0, 0, 1'b0);
      chk("t2_ram_we_pulses", 64'(we_cnt[0] - w0), 64'd1);
      c = cyc;
      push_exp(0, 0, 32'hDEAD_BEEF, c + 3);
      drive(0, 0, 1'b0, 10'h005, 32'h0);
      wait_ack(0, 0, 1'b0);

      // T6: requester withdraws during WAIT; the read still completes exactly once.
      c = cyc;
      push_exp(0, 0, 32'hDEAD_BEEF, c + 3);
      drive(0, 0, 1'b0, 10'h005, 32'h0);
      tick(2);
      req[0] = 1'b0;
      wait_ack(0, 0, 1'b0);
      b0 = busy_cnt_a;
      tick(10);
      chk("t6_no_second_txn", 64'(busy_cnt_a - b0), 64'd0);

      // T3: CPU priority, both requesting; port 0 wins twice before port 1 is served.
      c = cyc;
      push_exp(0, 0, 32'hDEAD_BEEF, c + 3);
      push_exp(0, 0, 32'h1000_0006, c + 7);
      push_exp(0, 1, 32'h1000_0010, c + 11);
      fork
         begin
            drive(0, 0, 1'b0, 10'h005, 32'h0);
            wait_ack(0, 0, 1'b1);
            drive(0, 0, 1'b0, 10'h006, 32'h0);
            wait_ack(0, 0, 1'b0);
         end
         begin
            drive(0, 1, 1'b0, 10'h010, 32'h0);
            wait_ack(0, 1, 1'b0);
         end
      join
      tick(2);

      // T4: round-robin with both held; grants alternate 0,1,0,1 (RD_LAT=3).
      c = cyc;
      push_exp(1, 0, 32'h1000_0001, c + 5);
      push_exp(1, 1, 32'h1000_0003, c + 11);
      push_exp(1, 0, 32'h1000_0002, c + 17);
      push_exp(1, 1, 32'h1000_0004, c + 23);
      fork
         begin
            drive(1, 0, 1'b0, 10'h001, 32'h0);
            wait_ack(1, 0, 1'b1);
            drive(1, 0, 1'b0, 10'h002, 32'h0);
            wait_ack(1, 0, 1'b0);
         end
         begin
            drive(1, 1, 1'b0, 10'h003, 32'h0);
            wait_ack(1, 1, 1'b1);
            drive(1, 1, 1'b0, 10'h004, 32'h0);
            wait_ack(1, 1, 1'b0);
         end
      join
      tick(2);

      // T5: RD_LAT=3, port 1 reads the top address.
      c = cyc;
      push_exp(1, 1, 32'h1000_03FF, c + 5);
      drive(1, 1, 1'b0, 10'h3FF, 32'h0);
      tick(1);
      chk("t5_ram_addr_issue", 64'(ram_addr[1*AW +: AW]), 64'h3FF);
      chk("t5_ram_we_read", 64'(ram_we[1]), 64'd0);
      wait_ack(1, 1, 1'b0);

      tick(6);
      chk("exp_queues_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
